up_sequencer: RTL

- Parametrised fetch/execute sequencer for the nibbler-family processor. It supersedes the fixed 12-bit program counter, the toggle phase flop and the 8-bit fetch register.
- Adds four things the current core lacks: a wait-state ROM handshake, a call/return stack, halt/resume, and configurable widths.
- Sits between program memory and the opcode decoder. The decoder supplies PC-control strobes during the execute phase.

---
 rtl/up_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/up_sequencer.sv
// Purpose : fetch/execute sequencer; program counter, fetch register, return stack, halt/resume.
// Latency : fetch is 1 cycle + ROM wait states; EXEC lasts exactly one cycle.
// Backpressure: FETCH holds rom_req and pc steady until rom_ack; HALTED holds until resume.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   rom_addr/rom_req        program address (== pc) and fetch request
//   rom_ack/rom_data        ROM data-valid strobe and fetched instruction word
//   instr/oprnd             latched opcode / operand fields of the last fetched word
//   phase, halted           1 in EXEC / 1 in HALTED
//   pc                      program counter
//   inc_pc, load_pc, load_addr, call, ret, halt   PC-control strobes (EXEC only)
//   resume                  leave HALTED (HALTED only)
//   sp, stack_err           return-stack occupancy, sticky overflow/underflow flag
module up_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int OP_W        = 4,
  parameter int OPR_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic [ADDR_W-1:0]                rom_addr,
  output logic                             rom_req,
  input  logic                             rom_ack,
  input  logic [OP_W+OPR_W-1:0]            rom_data,
  output logic [OP_W-1:0]                  instr,
  output logic [OPR_W-1:0]                 oprnd,
  output logic                             phase,
  output logic [ADDR_W-1:0]                pc,
  input  logic                             inc_pc,
  input  logic                             load_pc,
  input  logic [ADDR_W-1:0]                load_addr,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             halt,
  input  logic                             resume,
  output logic                             halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [OP_W-1:0]   r_instr;
  logic [OPR_W-1:0]  r_oprnd;
  logic [SP_W-1:0]   r_sp;
  logic              r_stack_err;
  logic              r_rom_req;
  logic              r_phase;
  logic              r_halted;

  // Storage is rounded up to a power of two so the index width matches exactly;
  // only the first STACK_DEPTH entries are ever written.
  logic [ADDR_W-1:0] r_stack [2**IDX_W];

  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;
  logic [SP_W-1:0]   w_sp_dec;
  logic [ADDR_W-1:0] w_top;

  // Push index is valid only when sp < STACK_DEPTH, so the low bits suffice.
  assign w_sp_dec   = r_sp - SP_W'(1);
  assign w_push_idx = r_sp[IDX_W-1:0];
  assign w_pop_idx  = w_sp_dec[IDX_W-1:0];
  assign w_top      = r_stack[w_pop_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_instr     <= '0;
      r_oprnd     <= '0;
      r_sp        <= '0;
      r_stack_err <= 1'b0;
      r_rom_req   <= 1'b1;
      r_phase     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (rom_ack) begin
            r_instr   <= rom_data[OP_W+OPR_W-1:OPR_W];
            r_oprnd   <= rom_data[OPR_W-1:0];
            r_pc      <= r_pc + ADDR_W'(1);
            r_state   <= S_EXEC;
            r_rom_req <= 1'b0;
            r_phase   <= 1'b1;
          end
        end

        S_EXEC: begin
          // Only the highest-priority strobe acts: ret > call > load_pc > inc_pc.
          if (ret) begin
            if (r_sp != '0) begin
              r_pc <= w_top;
              r_sp <= w_sp_dec;
            end else begin
              r_stack_err <= 1'b1;
            end
          end else if (call) begin
            if (r_sp != SP_FULL) begin
              r_stack[w_push_idx] <= r_pc;
              r_sp                <= r_sp + SP_W'(1);
              r_pc                <= load_addr;
            end else begin
              r_stack_err <= 1'b1;
            end
          end else if (load_pc) begin
            r_pc <= load_addr;
          end else if (inc_pc) begin
            r_pc <= r_pc + ADDR_W'(1);
          end

          r_phase <= 1'b0;
          if (halt) begin
            r_state   <= S_HALTED;
            r_halted  <= 1'b1;
            r_rom_req <= 1'b0;
          end else begin
            r_state   <= S_FETCH;
            r_rom_req <= 1'b1;
          end
        end

        S_HALTED: begin
          if (resume) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_rom_req <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_FETCH;
          r_rom_req <= 1'b1;
          r_phase   <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr  = r_pc;
  assign pc        = r_pc;
  assign rom_req   = r_rom_req;
  assign phase     = r_phase;
  assign halted    = r_halted;
  assign instr     = r_instr;
  assign oprnd     = r_oprnd;
  assign sp        = r_sp;
  assign stack_err = r_stack_err;

endmodule
